dvp_frame_ctrl: RTL and testbench

Frame-level sequencer that sits between the DVP-to-AXI-Stream converter and the downstream filter pipeline. It arms on software command, aligns capture to a vsync frame boundary and marks frame start with `tuser`. It checks line length and line count against the configured resolution, drops the rest of a frame on overflow, and reports completion and errors. The upstream pixel stream has no backpressure, so every stall-induced loss is detected and reported here.

---
 rtl/dvp_frame_ctrl.sv | 185 ++++++++++++++++++
 tb/tb_dvp_frame_ctrl.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dvp_frame_ctrl.sv
// rtl/dvp_frame_ctrl.sv - frame-level sequencer between the DVP converter and the filter pipeline
//
// Arms on start_i and waits for a vsync falling edge. It then captures one frame
// into a single-slot output register, and marks the first beat with m_tuser_o.
// It checks line length and line count against H_RES_P x V_RES_P. If a beat
// arrives while the slot is still held, the rest of the frame is dropped. Each
// completed frame produces a frame_done_o pulse.
//
// Ports:
//   pclk_i, rstn_i           clock, synchronous active-low reset
//   vsync_i                  frame sync (falling edge = frame start)
//   start_i, stop_i          arm / stop-after-frame commands
//   continuous_i             re-arm after every frame
//   s_tdata_i/tvalid_i/tlast_i  upstream pixel stream (no backpressure)
//   m_tdata_o/tvalid_o/tlast_o/tuser_o, m_tready_i  downstream stream
//   busy_o, frame_done_o, err_o[2:0], frame_cnt_o[15:0]  status
//
// Optional feature macro: DVP_FRAME_CTRL_DECIM_EN. It adds decim_i[3:0], and only
// every (decim_i+1)-th frame boundary is captured.

module dvp_frame_ctrl #(
    parameter int WIDTH_P = 8,
    parameter int H_RES_P = 640,
    parameter int V_RES_P = 480
) (
    input  logic               pclk_i,
    input  logic               rstn_i,
    input  logic               vsync_i,
    input  logic               start_i,
    input  logic               stop_i,
    input  logic               continuous_i,
`ifdef DVP_FRAME_CTRL_DECIM_EN
    input  logic [3:0]         decim_i,
`endif
    input  logic [WIDTH_P-1:0] s_tdata_i,
    input  logic               s_tvalid_i,
    input  logic               s_tlast_i,
    output logic [WIDTH_P-1:0] m_tdata_o,
    output logic               m_tvalid_o,
    output logic               m_tlast_o,
    output logic               m_tuser_o,
    input  logic               m_tready_i,
    output logic               busy_o,
    output logic               frame_done_o,
    output logic [2:0]         err_o,
    output logic [15:0]        frame_cnt_o
);

    localparam int COL_W = $clog2(H_RES_P + 1);
    localparam int ROW_W = $clog2(V_RES_P + 1);
    localparam logic [COL_W-1:0] COL_LAST = COL_W'(H_RES_P - 1);
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(V_RES_P - 1);
    localparam logic [COL_W-1:0] COL_MAX  = {COL_W{1'b1}};
    localparam logic [ROW_W-1:0] ROW_MAX  = {ROW_W{1'b1}};

    typedef enum logic [2:0] {
        IDLE, WAIT_VS, CAPTURE, DROP, DRAIN, DONE
    } state_t;

    state_t           state, state_nxt;
    logic             vsync_d;
    logic             vs_fall, vs_rise;
    logic [COL_W-1:0] col_cnt;
    logic [ROW_W-1:0] row_cnt;
    logic             sof;
    logic             stop_pend;
    logic             slot_free, admit, lost, last_line_end, capture_go;

    assign vs_fall = vsync_d & ~vsync_i;
    assign vs_rise = ~vsync_d & vsync_i;

    // The slot can take a new beat if it is empty or is being emptied this cycle.
    assign slot_free     = ~m_tvalid_o | m_tready_i;
    assign admit         = (state == CAPTURE) & s_tvalid_i & slot_free;
    assign lost          = (state == CAPTURE) & s_tvalid_i & ~slot_free;
    assign last_line_end = admit & s_tlast_i & (row_cnt == ROW_LAST);

`ifdef DVP_FRAME_CTRL_DECIM_EN
    // dec_cnt counts the boundaries still to skip. Zero means the next one is captured.
    logic [3:0] dec_cnt;

    assign capture_go = (state == WAIT_VS) & vs_fall & (dec_cnt == 4'd0);

    always_ff @(posedge pclk_i) begin
        if (!rstn_i || state == IDLE) begin
            dec_cnt <= 4'd0;
        end else if (state == WAIT_VS && vs_fall) begin
            dec_cnt <= (dec_cnt == 4'd0) ? decim_i : dec_cnt - 4'd1;
        end
    end
`else
    assign capture_go = (state == WAIT_VS) & vs_fall;
`endif

    always_ff @(posedge pclk_i) begin
        if (!rstn_i) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start_i && !stop_i) state_nxt = WAIT_VS;
            WAIT_VS: begin
                if (capture_go)  state_nxt = CAPTURE;
                else if (stop_i) state_nxt = IDLE;
            end
            CAPTURE: begin
                if (last_line_end) state_nxt = DRAIN;
                else if (vs_rise)  state_nxt = DRAIN;
                else if (lost)     state_nxt = DROP;
            end
            DROP:    if (vs_rise) state_nxt = DRAIN;
            // Nothing loads in DRAIN, so a ready slot is empty next cycle.
            DRAIN:   if (!m_tvalid_o || m_tready_i) state_nxt = DONE;
            DONE:    state_nxt = (continuous_i && !stop_pend) ? WAIT_VS : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        busy_o       = (state != IDLE);
        frame_done_o = (state == DONE);
    end

    always_ff @(posedge pclk_i) begin
        if (!rstn_i) begin
            vsync_d     <= 1'b0;
            m_tdata_o   <= '0;
            m_tvalid_o  <= 1'b0;
            m_tlast_o   <= 1'b0;
            m_tuser_o   <= 1'b0;
            col_cnt     <= '0;
            row_cnt     <= '0;
            sof         <= 1'b0;
            stop_pend   <= 1'b0;
            err_o       <= 3'b000;
            frame_cnt_o <= 16'd0;
        end else begin
            vsync_d <= vsync_i;

            // Output slot: data fields only change on a load, so they hold while stalled.
            if (admit) begin
                m_tvalid_o <= 1'b1;
                m_tdata_o  <= s_tdata_i;
                m_tlast_o  <= s_tlast_i;
                m_tuser_o  <= sof;
            end else if (m_tready_i) begin
                m_tvalid_o <= 1'b0;
            end

            if (capture_go) begin
                col_cnt <= '0;
                row_cnt <= '0;
                sof     <= 1'b1;
            end else if (admit) begin
                sof <= 1'b0;
                if (s_tlast_i) begin
                    if (col_cnt != COL_LAST) err_o[0] <= 1'b1;
                    col_cnt <= '0;
                    if (row_cnt != ROW_MAX) row_cnt <= row_cnt + 1'b1;
                end else if (col_cnt != COL_MAX) begin
                    col_cnt <= col_cnt + 1'b1;
                end
            end

            if (state == IDLE && start_i && !stop_i) err_o <= 3'b000;
            if (state == CAPTURE && vs_rise && !last_line_end) err_o[1] <= 1'b1;
            if (lost) err_o[2] <= 1'b1;

            if (state == IDLE) begin
                stop_pend <= 1'b0;
            end else if (stop_i && (state == WAIT_VS || state == CAPTURE ||
                                    state == DROP || state == DRAIN)) begin
                stop_pend <= 1'b1;
            end

            if (state == DONE) frame_cnt_o <= frame_cnt_o + 16'd1;
        end
    end

endmodule

// File: tb/tb_dvp_frame_ctrl.sv
// tb/tb_dvp_frame_ctrl.sv - self-checking bench for dvp_frame_ctrl (4x3 frames)

module tb_dvp_frame_ctrl;

    localparam int W = 8;
    localparam int H = 4;
    localparam int V = 3;

    logic         clk = 1'b0;
    logic         rstn = 1'b0;
    logic         vsync = 1'b1;
    logic         start = 1'b0;
    logic         stop = 1'b0;
    logic         cont = 1'b0;
    logic [W-1:0] s_tdata = '0;
    logic         s_tvalid = 1'b0;
    logic         s_tlast = 1'b0;
    logic [W-1:0] m_tdata;
    logic         m_tvalid, m_tlast, m_tuser;
    logic         m_tready = 1'b1;
    logic         busy, frame_done;
    logic [2:0]   err;
    logic [15:0]  frame_cnt;
`ifdef DVP_FRAME_CTRL_DECIM_EN
    logic [3:0]   decim = 4'd0;
`endif

    always #5 clk = ~clk;

    dvp_frame_ctrl #(.WIDTH_P(W), .H_RES_P(H), .V_RES_P(V)) dut (
        .pclk_i(clk), .rstn_i(rstn), .vsync_i(vsync),
        .start_i(start), .stop_i(stop), .continuous_i(cont),
`ifdef DVP_FRAME_CTRL_DECIM_EN
        .decim_i(decim),
`endif
        .s_tdata_i(s_tdata), .s_tvalid_i(s_tvalid), .s_tlast_i(s_tlast),
        .m_tdata_o(m_tdata), .m_tvalid_o(m_tvalid), .m_tlast_o(m_tlast),
        .m_tuser_o(m_tuser), .m_tready_i(m_tready),
        .busy_o(busy), .frame_done_o(frame_done), .err_o(err), .frame_cnt_o(frame_cnt)
    );

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int pix = 0;
    int first_in_cyc = 0;
    logic mon_clr = 1'b0;
    logic chk_data = 1'b1;

    // Monitor state
    int          beat_cnt = 0, done_cnt = 0, data_bad = 0, stall_bad = 0;
    int          first_out_cyc = 0, last_acc_cyc = 0, done_cyc = 0;
    logic [31:0] user_mask = '0, last_mask = '0;
    logic        held_v = 1'b0;
    logic [W+1:0] held = '0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (!rstn) begin
            held_v <= 1'b0;
        end else if (mon_clr) begin
            beat_cnt <= 0; done_cnt <= 0; data_bad <= 0; stall_bad <= 0;
            first_out_cyc <= 0; last_acc_cyc <= 0; done_cyc <= 0;
            user_mask <= '0; last_mask <= '0; held_v <= 1'b0;
        end else begin
            if (held_v && (!m_tvalid || {m_tdata, m_tlast, m_tuser} != held))
                stall_bad <= stall_bad + 1;
            if (m_tvalid && m_tready) begin
                if (beat_cnt == 0) first_out_cyc <= cyc;
                if (chk_data && m_tdata != W'(beat_cnt)) data_bad <= data_bad + 1;
                if (beat_cnt < 32) begin
                    user_mask[beat_cnt[4:0]] <= m_tuser;
                    last_mask[beat_cnt[4:0]] <= m_tlast;
                end
                beat_cnt     <= beat_cnt + 1;
                last_acc_cyc <= cyc;
            end
            if (frame_done) begin
                done_cnt <= done_cnt + 1;
                done_cyc <= cyc;
            end
            held_v <= m_tvalid && !m_tready;
            held   <= {m_tdata, m_tlast, m_tuser};
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic clear_mon;
        pix = 0;
        mon_clr = 1'b1;
        @(negedge clk);
        #1;
        mon_clr = 1'b0;
        tick();
    endtask

    task automatic pulse_start;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic frame_start;
        vsync = 1'b1;
        repeat (3) tick();
        vsync = 1'b0;
        repeat (2) tick();
    endtask

    task automatic frame_end;
        vsync = 1'b1;
        repeat (4) tick();
    endtask

    task automatic send_line(input int len);
        for (int i = 0; i < len; i++) begin
            if (pix == 0) first_in_cyc = cyc;
            s_tvalid = 1'b1;
            s_tdata  = W'(pix);
            s_tlast  = (i == len - 1);
            pix++;
            tick();
        end
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
        repeat (2) tick();
    endtask

    typedef struct {
        string       name;
        int          l0, l1, l2, nl;
        int          beats;
        logic [31:0] user_m;
        logic [31:0] last_m;
        logic [2:0]  err;
        int          fcnt;
        bit          lat;
    } vec_t;

    vec_t vecs[5];

    initial begin
        vecs[0] = '{"clean",       4, 4, 4, 3, 12, 32'h1, 32'h888,  3'b000, 1, 1'b1};
        vecs[1] = '{"long_line",   4, 5, 4, 3, 13, 32'h1, 32'h1108, 3'b001, 2, 1'b1};
        vecs[2] = '{"short_line",  4, 3, 4, 3, 11, 32'h1, 32'h448,  3'b001, 3, 1'b1};
        vecs[3] = '{"short_frame", 4, 4, 0, 2,  8, 32'h1, 32'h88,   3'b010, 4, 1'b0};
        vecs[4] = '{"clean_again", 4, 4, 4, 3, 12, 32'h1, 32'h888,  3'b000, 5, 1'b1};

        // Reset values
        repeat (3) tick();
        check("rst_m_tvalid", 32'(m_tvalid), 0);
        check("rst_m_tdata", 32'(m_tdata), 0);
        check("rst_m_tlast", 32'(m_tlast), 0);
        check("rst_m_tuser", 32'(m_tuser), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_frame_done", 32'(frame_done), 0);
        check("rst_err", 32'(err), 0);
        check("rst_frame_cnt", 32'(frame_cnt), 0);
        rstn = 1'b1;
        tick();

        // start and stop together: stop wins
        start = 1'b1; stop = 1'b1;
        tick();
        start = 1'b0; stop = 1'b0;
        tick();
        check("start_stop_idle_busy", 32'(busy), 0);
        // stop in WAIT_VS returns to IDLE
        pulse_start();
        check("armed_busy", 32'(busy), 1);
        stop = 1'b1;
        tick();
        stop = 1'b0;
        check("stop_wait_vs_busy", 32'(busy), 0);

        // Table of single frames
        for (int i = 0; i < 5; i++) begin
            clear_mon();
            pulse_start();
            frame_start();
            send_line(vecs[i].l0);
            send_line(vecs[i].l1);
            if (vecs[i].nl > 2) send_line(vecs[i].l2);
            frame_end();
            repeat (2) tick();
            check({vecs[i].name, "_beats"}, 32'(beat_cnt), 32'(vecs[i].beats));
            check({vecs[i].name, "_tuser"}, user_mask, vecs[i].user_m);
            check({vecs[i].name, "_tlast"}, last_mask, vecs[i].last_m);
            check({vecs[i].name, "_err"}, 32'(err), 32'(vecs[i].err));
            check({vecs[i].name, "_done"}, 32'(done_cnt), 1);
            check({vecs[i].name, "_fcnt"}, 32'(frame_cnt), 32'(vecs[i].fcnt));
            check({vecs[i].name, "_busy"}, 32'(busy), 0);
            check({vecs[i].name, "_data"}, 32'(data_bad), 0);
            if (vecs[i].lat) begin
                check({vecs[i].name, "_in_out_lat"}, 32'(first_out_cyc), 32'(first_in_cyc + 1));
                check({vecs[i].name, "_done_lat"}, 32'(done_cyc), 32'(last_acc_cyc + 1));
            end
        end

        // Overflow: ready low on global beats 6 and 7 (line 1, cols 2-3)
        clear_mon();
        pulse_start();
        frame_start();
        for (int i = 0; i < 12; i++) begin
            m_tready = !(i == 6 || i == 7);
            s_tvalid = 1'b1;
            s_tdata  = W'(i);
            s_tlast  = (i % 4 == 3);
            tick();
        end
        s_tvalid = 1'b0; s_tlast = 1'b0; m_tready = 1'b1;
        repeat (2) tick();
        check("ovf_beats", 32'(beat_cnt), 6);
        check("ovf_err", 32'(err), 32'h4);
        check("ovf_no_done_before_vs", 32'(done_cnt), 0);
        check("ovf_busy_in_drop", 32'(busy), 1);
        frame_end();
        repeat (2) tick();
        check("ovf_done", 32'(done_cnt), 1);
        check("ovf_fcnt", 32'(frame_cnt), 6);
        check("ovf_busy", 32'(busy), 0);
        check("ovf_tlast", last_mask, 32'h8);
        check("ovf_data", 32'(data_bad), 0);
        check("ovf_stall_stable", 32'(stall_bad), 0);

        // Continuous with stop during frame 2
        clear_mon();
        cont = 1'b1;
        pulse_start();
        frame_start();
        repeat (3) send_line(4);
        frame_start();
        send_line(4);
        stop = 1'b1;
        tick();
        stop = 1'b0;
        repeat (2) send_line(4);
        frame_start();
        repeat (3) send_line(4);
        frame_end();
        repeat (2) tick();
        cont = 1'b0;
        check("cont_beats", 32'(beat_cnt), 24);
        check("cont_done", 32'(done_cnt), 2);
        check("cont_fcnt", 32'(frame_cnt), 8);
        check("cont_busy", 32'(busy), 0);
        check("cont_tuser", user_mask, 32'h1001);
        check("cont_err", 32'(err), 0);
        check("cont_data", 32'(data_bad), 0);

`ifdef DVP_FRAME_CTRL_DECIM_EN
        // decim=2: boundaries 1 and 4 of six are captured
        clear_mon();
        chk_data = 1'b0;
        decim = 4'd2;
        cont = 1'b1;
        pulse_start();
        repeat (6) begin
            frame_start();
            repeat (3) send_line(4);
        end
        stop = 1'b1;
        tick();
        stop = 1'b0;
        cont = 1'b0;
        repeat (2) tick();
        check("decim_done", 32'(done_cnt), 2);
        check("decim_beats", 32'(beat_cnt), 24);
        check("decim_fcnt", 32'(frame_cnt), 10);
        check("decim_busy", 32'(busy), 0);
        chk_data = 1'b1;
`endif

        // Reset mid-frame with a held beat
        pulse_start();
        frame_start();
        m_tready = 1'b0;
        s_tvalid = 1'b1; s_tdata = 8'hA5; s_tlast = 1'b0;
        tick();
        s_tvalid = 1'b0;
        tick();
        check("midrst_held_valid", 32'(m_tvalid), 1);
        check("midrst_held_data", 32'(m_tdata), 32'hA5);
        check("midrst_held_tuser", 32'(m_tuser), 1);
        rstn = 1'b0;
        tick();
        check("midrst_m_tvalid", 32'(m_tvalid), 0);
        check("midrst_m_tdata", 32'(m_tdata), 0);
        check("midrst_m_tuser", 32'(m_tuser), 0);
        check("midrst_busy", 32'(busy), 0);
        check("midrst_frame_cnt", 32'(frame_cnt), 0);
        rstn = 1'b1;
        m_tready = 1'b1;
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
